load_store_unit: RTL and testbench

Memory-access stage downstream of execution in the 3-stage RISC-V core. It takes one load/store request per instruction (address already computed by execution) and runs it on a single-outstanding data-memory bus with a request/grant/response handshake. It sign- or zero-extends load data and writes it back to register_file. It stalls the pipeline while an access is in flight, and flags misaligned or illegal accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage on a single-outstanding req/gnt/rvalid data bus
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_addr,
  output logic        req_done,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_wen,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;

  logic          legal;
  logic          timeout_hit;
  logic          done_int, mis_int, to_int, ld_done;
  logic [31:0]   wdata_nxt;
  logic [3:0]    wstrb_nxt;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Size is funct3[1:0]; RV64 widths and unsigned stores are rejected.
  always_comb begin
    legal = 1'b1;
    if (req_we) begin
      if (req_funct3[2] || req_funct3[1:0] == 2'b11) legal = 1'b0;
    end else if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) begin
      legal = 1'b0;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) legal = 1'b0;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) legal = 1'b0;
  end

  always_comb begin
    wdata_nxt = req_wdata;
    wstrb_nxt = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        wdata_nxt = {4{req_wdata[7:0]}};
        wstrb_nxt = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_nxt = {2{req_wdata[15:0]}};
        wstrb_nxt = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_nxt = req_wdata;
        wstrb_nxt = 4'b1111;
      end
    endcase
    if (!req_we) wstrb_nxt = 4'b0000;
  end

  always_comb begin
    ld_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (state != IDLE) && (cnt == CW'(TIMEOUT_CYCLES));

  // Timeout wins over a grant/response arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    done_int  = 1'b0;
    mis_int   = 1'b0;
    to_int    = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            state_nxt = REQ;
          end else begin
            done_int = 1'b1;
            mis_int  = 1'b1;
          end
        end
      end
      REQ: begin
        if (timeout_hit) begin
          done_int  = 1'b1;
          to_int    = 1'b1;
          state_nxt = IDLE;
        end else if (mem_gnt) begin
          if (mem_we) begin
            done_int  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (timeout_hit) begin
          done_int  = 1'b1;
          to_int    = 1'b1;
          state_nxt = IDLE;
        end else if (mem_rvalid) begin
          done_int  = 1'b1;
          ld_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are held low while reset is asserted.
  assign req_done     = sys_rst_n & done_int;
  assign err_misalign = sys_rst_n & mis_int;
  assign err_timeout  = sys_rst_n & to_int;
  assign stall        = sys_rst_n & req_valid & ~done_int;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      rd_q      <= 5'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      wb_wen    <= 1'b0;
      wb_addr   <= 5'd0;
      wb_data   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + CW'(1);

      if (state == IDLE && req_valid && legal) begin
        mem_req   <= 1'b1;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= wdata_nxt;
        mem_wstrb <= wstrb_nxt;
        f3_q      <= req_funct3;
        lo_q      <= req_addr[1:0];
        rd_q      <= req_rd_addr;
      end else if (state == REQ && state_nxt != REQ) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'd0;
      end

      wb_wen <= ld_done && (rd_q != 5'd0);
      if (ld_done) begin
        wb_addr <= rd_q;
        wb_data <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd_addr;
  logic        req_done, stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err_misalign, err_timeout;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd_addr(req_rd_addr),
    .req_done(req_done), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        exp_err;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wen;
    logic [31:0] exp_wb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, logic [4:0] rd, logic exp_err,
                              logic [31:0] exp_maddr, logic [31:0] exp_mwdata, logic [3:0] exp_wstrb,
                              logic exp_wen, logic [31:0] exp_wb, int exp_lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.exp_err = exp_err; v.exp_maddr = exp_maddr; v.exp_mwdata = exp_mwdata;
    v.exp_wstrb = exp_wstrb; v.exp_wen = exp_wen; v.exp_wb = exp_wb; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Latency counts negedges from the first cycle req_valid is high up to the done cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    logic        saw, done, got_err, got_to, got_stall;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_st;
    logic        c_we;
    cyc = 0; saw = 0; done = 0; got_err = 0; got_to = 0; got_stall = 0;
    c_addr = '0; c_wd = '0; c_st = '0; c_we = 0;
    @(posedge sys_clk); #1;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd_addr = v.rd; mem_rdata = v.rdata;
    while (!done && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
      if (mem_req && !saw) begin
        saw = 1; c_addr = mem_addr; c_wd = mem_wdata; c_st = mem_wstrb; c_we = mem_we;
      end
      if (req_done) begin
        done = 1; got_err = err_misalign; got_to = err_timeout; got_stall = stall;
      end
    end
    chk($sformatf("v%0d done_seen", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_lat));
    chk($sformatf("v%0d err_misalign", idx), 32'(got_err), 32'(v.exp_err));
    chk($sformatf("v%0d err_timeout", idx), 32'(got_to), 32'd0);
    chk($sformatf("v%0d stall_at_done", idx), 32'(got_stall), 32'd0);
    if (v.exp_err) begin
      chk($sformatf("v%0d no_bus_req", idx), 32'(saw), 32'd0);
    end else begin
      chk($sformatf("v%0d mem_addr", idx), c_addr, v.exp_maddr);
      chk($sformatf("v%0d mem_wdata", idx), c_wd, v.exp_mwdata);
      chk($sformatf("v%0d mem_wstrb", idx), 32'(c_st), 32'(v.exp_wstrb));
      chk($sformatf("v%0d mem_we", idx), 32'(c_we), 32'(v.we));
    end
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    @(negedge sys_clk);
    chk($sformatf("v%0d wb_wen", idx), 32'(wb_wen), 32'(v.exp_wen));
    if (v.exp_wen) begin
      chk($sformatf("v%0d wb_addr", idx), 32'(wb_addr), 32'(v.rd));
      chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb);
    end
    chk($sformatf("v%0d mem_req_dropped", idx), 32'(mem_req), 32'd0);
    @(negedge sys_clk);
    chk($sformatf("v%0d wb_wen_one_cycle", idx), 32'(wb_wen), 32'd0);
  endtask

  function automatic logic [15:0] ctl_bits();
    return {mem_req, mem_we, mem_wstrb, wb_wen, wb_addr, err_misalign, err_timeout, req_done, stall};
  endfunction

  initial begin
    int   cyc;
    logic done, got_to, got_mis, saw_req;

    vecs[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 2);
    vecs[1]  = mk(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 32'h100, 32'hA5A5A5A5, 4'h8, 0, 0, 2);
    vecs[2]  = mk(1, 3'b001, 32'h102, 32'h00001234, 0, 0, 0, 32'h100, 32'h12341234, 4'hC, 0, 0, 2);
    vecs[3]  = mk(0, 3'b000, 32'h101, 0, 32'h000080FF, 5, 0, 32'h100, 0, 4'h0, 1, 32'hFFFFFF80, 3);
    vecs[4]  = mk(0, 3'b100, 32'h101, 0, 32'h000080FF, 5, 0, 32'h100, 0, 4'h0, 1, 32'h00000080, 3);
    vecs[5]  = mk(0, 3'b010, 32'h102, 0, 0, 4, 1, 0, 0, 4'h0, 0, 0, 1);
    vecs[6]  = mk(0, 3'b011, 32'h100, 0, 0, 4, 1, 0, 0, 4'h0, 0, 0, 1);
    vecs[7]  = mk(0, 3'b101, 32'h002, 0, 32'hFFFE0000, 7, 0, 32'h000, 0, 4'h0, 1, 32'h0000FFFE, 3);
    vecs[8]  = mk(0, 3'b010, 32'h200, 0, 32'h12345678, 0, 0, 32'h200, 0, 4'h0, 0, 0, 3);
    vecs[9]  = mk(1, 3'b000, 32'h001, 32'h0000005A, 0, 0, 0, 32'h000, 32'h5A5A5A5A, 4'h2, 0, 0, 2);
    vecs[10] = mk(1, 3'b001, 32'h000, 32'h0000BEEF, 0, 0, 0, 32'h000, 32'hBEEFBEEF, 4'h3, 0, 0, 2);
    vecs[11] = mk(1, 3'b100, 32'h010, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0, 1);
    vecs[12] = mk(0, 3'b000, 32'h003, 0, 32'h7F000000, 31, 0, 32'h000, 0, 4'h0, 1, 32'h0000007F, 3);
    vecs[13] = mk(0, 3'b010, 32'h010, 0, 32'hCAFEF00D, 12, 0, 32'h010, 0, 4'h0, 1, 32'hCAFEF00D, 3);
    vecs[14] = mk(1, 3'b001, 32'h101, 32'h1234, 0, 0, 1, 0, 0, 4'h0, 0, 0, 1);

    sys_rst_n = 1'b0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd_addr = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_ctl", 32'(ctl_bits()), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Grant withheld: abort after 4 cycles of waiting, then a late gnt/rvalid must be ignored.
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge sys_clk); #1;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd_addr = 5'd3;
    mem_rdata = 32'h55555555;
    cyc = 0; done = 0; got_to = 0; got_mis = 0; saw_req = 0;
    while (!done && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
      if (mem_req) saw_req = 1;
      if (req_done) begin done = 1; got_to = err_timeout; got_mis = err_misalign; end
    end
    chk("to_done_seen", 32'(done), 32'd1);
    chk("to_latency", 32'(cyc), 32'd6);
    chk("to_err_timeout", 32'(got_to), 32'd1);
    chk("to_err_misalign", 32'(got_mis), 32'd0);
    chk("to_mem_req_seen", 32'(saw_req), 32'd1);
    @(posedge sys_clk); #1;
    req_valid = 0; mem_gnt = 1; mem_rvalid = 1;
    @(negedge sys_clk);
    chk("to_late_done", 32'(req_done), 32'd0);
    chk("to_mem_req_low", 32'(mem_req), 32'd0);
    chk("to_no_wb", 32'(wb_wen), 32'd0);
    @(posedge sys_clk); #1;
    mem_gnt = 0; mem_rvalid = 0;
    @(negedge sys_clk);
    chk("to_late_no_wb", 32'(wb_wen), 32'd0);
    chk("to_late_no_req", 32'(mem_req), 32'd0);
    mem_gnt = 1; mem_rvalid = 1;
    run_vec(100, mk(1, 3'b010, 32'h44, 32'h0BADF00D, 0, 0, 0, 32'h44, 32'h0BADF00D, 4'hF, 0, 0, 2));

    // Reset asserted while the load waits for its response.
    mem_gnt = 1; mem_rvalid = 0;
    @(posedge sys_clk); #1;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h80;
    req_wdata = 32'h11223344; req_rd_addr = 5'd9;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("wait_stall", 32'(stall), 32'd1);
    chk("wait_mem_addr", mem_addr, 32'h80);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 32'(ctl_bits()), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    req_valid = 0; mem_rvalid = 1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_vec(101, mk(0, 3'b001, 32'h002, 0, 32'hFFFE0000, 9, 0, 32'h000, 0, 4'h0, 1, 32'hFFFFFFFE, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
